// File: rtl/cci_host_mem_responder.sv
// -----------------------------------------------------------------------------
// cci_host_mem_responder
//
// Host-side memory model that sits at the far end of the AFU CCI request
// channels in unit benches.
//  - c0: read requests are looked up in a line-wide RAM on the request edge.
//        Data and tag then ride an RD_LATENCY-deep shift line to the response
//        port.
//  - c1: write requests commit to the RAM on the request edge. The tag rides
//        a WR_LATENCY-deep shift line to the ack port.
//  - An outstanding-read counter drives the advisory rd_almfull flag.
//
// Optional feature (compile-time macro CCI_HOST_MEM_OOR_CHECK_EN):
//   defined     : addresses >= DEPTH are out of range. Such reads return zero
//                 data and such writes are dropped, but both still respond.
//                 The sticky err flag sets on the request edge.
//   not defined : upper address bits are ignored (aliasing modulo DEPTH) and
//                 err is tied 0.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   rd_req_valid/addr/mdata           c0 read request
//   rd_almfull                        registered (outstanding reads >= ALMFULL_THRESH)
//   rd_rsp_valid/data/mdata           c0 read response (data/mdata are 0 when not valid)
//   wr_req_valid/addr/data/mdata      c1 write request
//   wr_rsp_valid/mdata                c1 write ack (mdata is 0 when not valid)
//   err                               sticky out-of-range flag
// -----------------------------------------------------------------------------
module cci_host_mem_responder #(
    parameter int CL_ADDR_W      = 42,
    parameter int DEPTH          = 64,
    parameter int MDATA_W        = 16,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 2,
    parameter int ALMFULL_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rd_req_valid,
    input  logic [CL_ADDR_W-1:0] rd_req_addr,
    input  logic [MDATA_W-1:0]   rd_req_mdata,
    output logic                 rd_almfull,
    output logic                 rd_rsp_valid,
    output logic [511:0]         rd_rsp_data,
    output logic [MDATA_W-1:0]   rd_rsp_mdata,
    input  logic                 wr_req_valid,
    input  logic [CL_ADDR_W-1:0] wr_req_addr,
    input  logic [511:0]         wr_req_data,
    input  logic [MDATA_W-1:0]   wr_req_mdata,
    output logic                 wr_rsp_valid,
    output logic [MDATA_W-1:0]   wr_rsp_mdata,
    output logic                 err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALMFULL_THRESH);

    logic [511:0]       mem [DEPTH];
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_oor;
    logic               wr_oor;
    logic               unused_upper_addr;

    logic               rd_vld_p   [RD_LATENCY];
    logic [511:0]       rd_data_p  [RD_LATENCY];
    logic [MDATA_W-1:0] rd_mdata_p [RD_LATENCY];
    logic               wr_vld_p   [WR_LATENCY];
    logic [MDATA_W-1:0] wr_mdata_p [WR_LATENCY];

    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   rd_cnt_nxt;

    assign rd_idx = rd_req_addr[IDX_W-1:0];
    assign wr_idx = wr_req_addr[IDX_W-1:0];

`ifdef CCI_HOST_MEM_OOR_CHECK_EN
    logic err_q;

    assign rd_oor = |rd_req_addr[CL_ADDR_W-1:IDX_W];
    assign wr_oor = |wr_req_addr[CL_ADDR_W-1:IDX_W];
    assign err    = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((rd_req_valid && rd_oor) || (wr_req_valid && wr_oor)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
    assign err    = 1'b0;
`endif

    // Upper bits only matter when the range check is compiled in.
    assign unused_upper_addr = ^{rd_req_addr[CL_ADDR_W-1:IDX_W], wr_req_addr[CL_ADDR_W-1:IDX_W]};

    // A simultaneous accept and retire cancel out.
    always_comb begin
        rd_cnt_nxt = rd_cnt;
        case ({rd_req_valid, rd_rsp_valid})
            2'b10:   rd_cnt_nxt = rd_cnt + CNT_W'(1);
            2'b01:   rd_cnt_nxt = rd_cnt - CNT_W'(1);
            default: rd_cnt_nxt = rd_cnt;
        endcase
    end

    // Stage p0 .. p(N-1): valid bits and the counter are the only reset state,
    // so a reset discards everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) rd_vld_p[i] <= 1'b0;
            for (int i = 0; i < WR_LATENCY; i++) wr_vld_p[i] <= 1'b0;
            rd_cnt     <= '0;
            rd_almfull <= 1'b0;
        end else begin
            rd_vld_p[0] <= rd_req_valid;
            for (int i = 1; i < RD_LATENCY; i++) rd_vld_p[i] <= rd_vld_p[i-1];
            wr_vld_p[0] <= wr_req_valid;
            for (int i = 1; i < WR_LATENCY; i++) wr_vld_p[i] <= wr_vld_p[i-1];
            rd_cnt     <= rd_cnt_nxt;
            rd_almfull <= (rd_cnt_nxt >= THRESH);
        end
    end

    // The RAM read and the RAM write share this edge. The non-blocking write
    // means a same-cycle read of the same line captures the old contents.
    always_ff @(posedge clk) begin
        if (wr_req_valid && !wr_oor) begin
            mem[wr_idx] <= wr_req_data;
        end
        rd_data_p[0]  <= rd_oor ? '0 : mem[rd_idx];
        rd_mdata_p[0] <= rd_req_mdata;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_data_p[i]  <= rd_data_p[i-1];
            rd_mdata_p[i] <= rd_mdata_p[i-1];
        end
        wr_mdata_p[0] <= wr_req_mdata;
        for (int i = 1; i < WR_LATENCY; i++) wr_mdata_p[i] <= wr_mdata_p[i-1];
    end

    // Payload is unreset, so gate it with valid to keep outputs 0 in reset.
    assign rd_rsp_valid = rd_vld_p[RD_LATENCY-1];
    assign rd_rsp_data  = rd_rsp_valid ? rd_data_p[RD_LATENCY-1] : '0;
    assign rd_rsp_mdata = rd_rsp_valid ? rd_mdata_p[RD_LATENCY-1] : '0;
    assign wr_rsp_valid = wr_vld_p[WR_LATENCY-1];
    assign wr_rsp_mdata = wr_rsp_valid ? wr_mdata_p[WR_LATENCY-1] : '0;

endmodule
